dac_sample_sequencer: RTL and testbench

- Parametrised multi-channel successor to the single 10-bit core-to-DAC path.
- Buffers samples produced by the RISC-V core in a FIFO and releases them at a programmable sample rate.
- Distributes released samples round-robin across NCH DAC channel registers.
- Handles FIFO underflow in a selectable mode; sits between riscv_pri output logic and one or more avsddac instances, clocked from the PLL clock.

---
 rtl/dac_sample_sequencer_pkg.sv | 22 ++
 rtl/dac_sample_sequencer_fifo.sv | 79 +++++++
 rtl/dac_sample_sequencer.sv | 152 +++++++++++++++
 tb/tb_dac_sample_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_sample_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// dac_sample_sequencer_pkg
//   Shared helpers for the DAC sample sequencer slice.
//   - ch_idx_w : width of a channel index, never less than one bit
//   - lvl_w    : width of a FIFO occupancy count (must be able to hold DEPTH)
//   - midscale : the code 1 << (dw-1), loaded on underflow in midscale mode
// ---------------------------------------------------------------------------
package dac_sample_sequencer_pkg;

   function automatic int ch_idx_w(input int nch);
      return (nch > 1) ? $clog2(nch) : 1;
   endfunction

   function automatic int lvl_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic logic [31:0] midscale(input int dw);
      return 32'd1 << (dw - 1);
   endfunction

endpackage

// File: rtl/dac_sample_sequencer_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
//   Synchronous FIFO holding samples from the core until the sequencer
//   releases them. Occupancy is kept in its own up/down counter so it does
//   not depend on pointer arithmetic; pointers wrap naturally (DEPTH is a
//   power of two). The head word is presented combinationally on rdata.
//
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     push, wdata write request and data (ignored when full)
//     pop         read request (ignored when empty)
//     rdata       current head word
//     full, empty occupancy flags from the registered level
//     level       number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module sample_fifo
   import dac_sample_sequencer_pkg::*;
#(
   parameter int DW    = 10,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [DW-1:0]              wdata,
   input  logic                       pop,
   output logic [DW-1:0]              rdata,
   output logic                       full,
   output logic                       empty,
   output logic [lvl_w(DEPTH)-1:0]    level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = lvl_w(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push, do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign level   = level_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage needs no reset: resetting the pointers and level discards it.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/dac_sample_sequencer.sv
// ---------------------------------------------------------------------------
// dac_sample_sequencer
//   Buffers core samples in a FIFO and releases one per sample period,
//   distributing them round-robin over NCH DAC channel registers. On a
//   period tick with an empty FIFO the sticky underflow flag is set and the
//   addressed channel either holds (mode_mid=0) or loads midscale (mode_mid=1).
//
//   Ports:
//     CLK, reset_n  PLL clock, asynchronous active-low reset
//     en            enable; low forces divider and channel pointer to 0
//     rate_div      sample period minus one, in CLK cycles
//     mode_mid      underflow mode select
//     in_data/in_valid/in_ready  sample input; a push is in_valid && in_ready
//     clr_uf        clears the underflow flag (a new underflow wins)
//     dac_out       channel registers, channel k at [k*DW +: DW]
//     dac_upd/upd_ch  registered strobe + channel, aligned with dac_out
//     underflow     sticky underflow flag
//     level         FIFO occupancy
//
//   Handshake: in_valid/in_ready follow valid/ready semantics; a word is
//   taken on any rising edge where both are high, and in_ready depends only
//   on registered occupancy, never on in_valid.
// ---------------------------------------------------------------------------
module dac_sample_sequencer
   import dac_sample_sequencer_pkg::*;
#(
   parameter int DW    = 10,
   parameter int NCH   = 2,
   parameter int DEPTH = 8,
   parameter int DIVW  = 16
) (
   input  logic                      CLK,
   input  logic                      reset_n,
   input  logic                      en,
   input  logic [DIVW-1:0]           rate_div,
   input  logic                      mode_mid,
   input  logic [DW-1:0]             in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      clr_uf,
   output logic [NCH*DW-1:0]         dac_out,
   output logic                      dac_upd,
   output logic [ch_idx_w(NCH)-1:0]  upd_ch,
   output logic                      underflow,
   output logic [lvl_w(DEPTH)-1:0]   level
);

   localparam int            CHW = ch_idx_w(NCH);
   localparam logic [DW-1:0] MID = DW'(midscale(DW));

   logic [DIVW-1:0]   cnt_q, cnt_d;
   logic [CHW-1:0]    ch_ptr_q, ch_ptr_d;
   logic [NCH*DW-1:0] dac_q, dac_d;
   logic              upd_q, upd_d;
   logic [CHW-1:0]    upd_ch_q, upd_ch_d;
   logic              uf_q, uf_d;

   logic              fifo_full, fifo_empty;
   logic [DW-1:0]     fifo_rdata;
   logic              push, tick, pop;
   logic              wr_en;
   logic [DW-1:0]     wr_val;

   assign in_ready = !fifo_full;
   assign push     = in_valid && in_ready;
   // Compared live: a rate_div lowered below cnt lets cnt run through the
   // full DIVW range before it matches again.
   assign tick     = en && (cnt_q == rate_div);
   // empty is registered, so a word pushed on this edge is not visible here.
   assign pop      = tick && !fifo_empty;

   sample_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .rst_n (reset_n),
      .push  (push),
      .wdata (in_data),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   always_comb begin
      cnt_d    = cnt_q;
      ch_ptr_d = ch_ptr_q;
      dac_d    = dac_q;
      upd_d    = 1'b0;
      upd_ch_d = upd_ch_q;
      uf_d     = uf_q;
      wr_en    = 1'b0;
      wr_val   = fifo_rdata;

      if (!en) begin
         cnt_d    = '0;
         ch_ptr_d = '0;
      end else if (tick) begin
         cnt_d    = '0;
         ch_ptr_d = (ch_ptr_q == CHW'(NCH - 1)) ? '0 : ch_ptr_q + 1'b1;
      end else begin
         cnt_d    = cnt_q + 1'b1;
      end

      if (pop) begin
         wr_en = 1'b1;
      end else if (tick && mode_mid) begin
         wr_en  = 1'b1;
         wr_val = MID;
      end

      if (tick && fifo_empty) begin
         uf_d = 1'b1;
      end else if (clr_uf) begin
         uf_d = 1'b0;
      end

      if (wr_en) begin
         upd_d    = 1'b1;
         upd_ch_d = ch_ptr_q;
         for (int k = 0; k < NCH; k++) begin
            if (ch_ptr_q == CHW'(k)) dac_d[k*DW +: DW] = wr_val;
         end
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         ch_ptr_q <= '0;
         dac_q    <= '0;
         upd_q    <= 1'b0;
         upd_ch_q <= '0;
         uf_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ch_ptr_q <= ch_ptr_d;
         dac_q    <= dac_d;
         upd_q    <= upd_d;
         upd_ch_q <= upd_ch_d;
         uf_q     <= uf_d;
      end
   end

   assign dac_out   = dac_q;
   assign dac_upd   = upd_q;
   assign upd_ch    = upd_ch_q;
   assign underflow = uf_q;

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dac_sample_sequencer
//   Scenario tasks drive the sequencer; every expected channel write is
//   pushed as {channel, value} into exp_q when the stimulus is applied and
//   popped whenever the DUT raises dac_upd.
// ---------------------------------------------------------------------------
module tb_dac_sample_sequencer;

   localparam int DW    = 10;
   localparam int NCH   = 2;
   localparam int DEPTH = 8;
   localparam int DIVW  = 16;
   localparam int CHW   = 1;
   localparam int LW    = 4;

   logic              CLK;
   logic              reset_n;
   logic              en;
   logic [DIVW-1:0]   rate_div;
   logic              mode_mid;
   logic [DW-1:0]     in_data;
   logic              in_valid;
   logic              in_ready;
   logic              clr_uf;
   logic [NCH*DW-1:0] dac_out;
   logic              dac_upd;
   logic [CHW-1:0]    upd_ch;
   logic              underflow;
   logic [LW-1:0]     level;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;
   int upd_cnt = 0;
   int last_upd_cyc = 0;
   logic [CHW+DW-1:0] exp_q[$];

   dac_sample_sequencer #(
      .DW(DW), .NCH(NCH), .DEPTH(DEPTH), .DIVW(DIVW)
   ) dut (
      .CLK       (CLK),
      .reset_n   (reset_n),
      .en        (en),
      .rate_div  (rate_div),
      .mode_mid  (mode_mid),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .clr_uf    (clr_uf),
      .dac_out   (dac_out),
      .dac_upd   (dac_upd),
      .upd_ch    (upd_ch),
      .underflow (underflow),
      .level     (level)
   );

   // ---------------- clock ----------------
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] ch_val(input int k);
      return dac_out[k*DW +: DW];
   endfunction

   function automatic logic [CHW+DW-1:0] exp_item(input int ch, input logic [DW-1:0] v);
      return {CHW'(ch), v};
   endfunction

   // One clock: outputs are sampled 1 time unit after the edge; any update
   // strobe is matched against the head of the expected queue.
   task automatic sb_cycle();
      logic [CHW+DW-1:0] e;
      int ech;
      @(posedge CLK);
      #1;
      cyc_n++;
      if (dac_upd) begin
         upd_cnt++;
         last_upd_cyc = cyc_n;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected_upd: got update ch=%0d dac_out=%h, required no update", upd_ch, dac_out);
         end else begin
            e   = exp_q.pop_front();
            ech = int'(e[CHW+DW-1:DW]);
            if (upd_ch !== e[CHW+DW-1:DW] || ch_val(ech) !== e[DW-1:0]) begin
               bad++;
               $display("FAIL sb_upd: got ch=%0d val=%h, required ch=%0d val=%h",
                        upd_ch, ch_val(int'(upd_ch)), ech, e[DW-1:0]);
            end
         end
      end
   endtask

   task automatic push_sample(input logic [DW-1:0] v);
      in_data  = v;
      in_valid = 1'b1;
      sb_cycle();
      in_valid = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      total++;
      if (dac_out !== '0 || dac_upd !== 1'b0 || upd_ch !== '0 || underflow !== 1'b0 ||
          level !== '0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_vals: got dac=%h upd=%b ch=%0d uf=%b lvl=%0d rdy=%b, required all 0 and rdy=1",
                  dac_out, dac_upd, upd_ch, underflow, level, in_ready);
      end
      reset_n = 1'b1;
      sb_cycle();
   endtask

   task automatic test_round_robin();
      int start;
      int base;
      en = 1'b0; rate_div = 16'd3; mode_mid = 1'b0;
      push_sample(10'h100); exp_q.push_back(exp_item(0, 10'h100));
      push_sample(10'h200); exp_q.push_back(exp_item(1, 10'h200));
      push_sample(10'h300); exp_q.push_back(exp_item(0, 10'h300));
      en    = 1'b1;
      start = cyc_n;
      base  = upd_cnt;
      for (int k = 1; k <= 3; k++) begin
         repeat (4) sb_cycle();
         total++;
         if (upd_cnt !== base + k || last_upd_cyc !== start + 4*k) begin
            bad++;
            $display("FAIL rr_timing_%0d: got updates=%0d last_at=%0d, required updates=%0d at=%0d",
                     k, upd_cnt - base, last_upd_cyc - start, k, 4*k);
         end
      end
      en = 1'b0;
      total++;
      if (exp_q.size() != 0 || level !== '0) begin
         bad++;
         $display("FAIL rr_drain: got pending=%0d level=%0d, required 0 and 0", exp_q.size(), level);
      end
      sb_cycle();
   endtask

   task automatic test_underflow_hold();
      en = 1'b0; rate_div = 16'd1; mode_mid = 1'b0;
      push_sample(10'h155); exp_q.push_back(exp_item(0, 10'h155));
      en = 1'b1;
      repeat (6) sb_cycle();  // pop on ch0, then underflow on ch1 and ch0
      total++;
      if (underflow !== 1'b1 || ch_val(0) !== 10'h155 || dac_upd !== 1'b0) begin
         bad++;
         $display("FAIL uf_hold: got uf=%b ch0=%h upd=%b, required uf=1 ch0=155 upd=0",
                  underflow, ch_val(0), dac_upd);
      end
      // The pointer moved past ch0 on the underflow, so this lands in ch1.
      push_sample(10'h0AA); exp_q.push_back(exp_item(1, 10'h0AA));
      sb_cycle();
      en = 1'b0;
      total++;
      if (underflow !== 1'b1 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL uf_advance: got uf=%b pending=%0d, required uf=1 pending=0", underflow, exp_q.size());
      end
      clr_uf = 1'b1;
      sb_cycle();
      clr_uf = 1'b0;
      total++;
      if (underflow !== 1'b0) begin
         bad++;
         $display("FAIL uf_clear: got uf=%b, required 0", underflow);
      end
   endtask

   task automatic test_underflow_mid();
      en = 1'b0; rate_div = 16'd0; mode_mid = 1'b1;
      sb_cycle();
      en = 1'b1;
      exp_q.push_back(exp_item(0, 10'h200));
      push_sample(10'h3C3);  // push and tick on the same edge, FIFO empty
      total++;
      if (ch_val(0) !== 10'h200 || dac_upd !== 1'b1 || underflow !== 1'b1 || level !== 4'd1) begin
         bad++;
         $display("FAIL uf_mid: got ch0=%h upd=%b uf=%b lvl=%0d, required 200 1 1 1",
                  ch_val(0), dac_upd, underflow, level);
      end
      exp_q.push_back(exp_item(1, 10'h3C3));
      sb_cycle();
      clr_uf = 1'b1;
      exp_q.push_back(exp_item(0, 10'h200));
      sb_cycle();
      clr_uf = 1'b0;
      en = 1'b0;
      mode_mid = 1'b0;
      total++;
      if (underflow !== 1'b1 || exp_q.size() != 0 || ch_val(1) !== 10'h3C3) begin
         bad++;
         $display("FAIL uf_set_beats_clr: got uf=%b pending=%0d ch1=%h, required 1 0 3c3",
                  underflow, exp_q.size(), ch_val(1));
      end
      sb_cycle();
   endtask

   task automatic test_reset_mid();
      en = 1'b0;
      for (int i = 0; i < 5; i++) push_sample(10'($urandom_range(0, 1023)));
      total++;
      if (level !== 4'd5 || underflow !== 1'b1) begin
         bad++;
         $display("FAIL rst_pre: got lvl=%0d uf=%b, required 5 1", level, underflow);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (dac_out !== '0 || level !== '0 || in_ready !== 1'b1 || underflow !== 1'b0) begin
         bad++;
         $display("FAIL rst_low: got dac=%h lvl=%0d rdy=%b uf=%b, required 0 0 1 0",
                  dac_out, level, in_ready, underflow);
      end
      repeat (2) @(posedge CLK);
      #1;
      reset_n = 1'b1;
      sb_cycle();
      total++;
      if (dac_out !== '0 || level !== '0 || in_ready !== 1'b1 || underflow !== 1'b0 || dac_upd !== 1'b0) begin
         bad++;
         $display("FAIL rst_after: got dac=%h lvl=%0d rdy=%b uf=%b upd=%b, required 0 0 1 0 0",
                  dac_out, level, in_ready, underflow, dac_upd);
      end
   endtask

   task automatic test_full_fifo();
      logic [DW-1:0] v;
      int base;
      en = 1'b0; rate_div = 16'd0; mode_mid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         total++;
         if (in_ready !== (i < DEPTH)) begin
            bad++;
            $display("FAIL full_ready_%0d: got rdy=%b, required %b", i, in_ready, (i < DEPTH));
         end
         v = 10'($urandom_range(0, 1023));
         if (i < DEPTH) exp_q.push_back(exp_item(i % NCH, v));
         push_sample(v);
      end
      total++;
      if (level !== 4'd8 || in_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_level: got lvl=%0d rdy=%b, required 8 0", level, in_ready);
      end
      base = upd_cnt;
      en = 1'b1;
      repeat (8) sb_cycle();
      en = 1'b0;
      total++;
      if (upd_cnt - base !== 8 || exp_q.size() != 0 || level !== '0) begin
         bad++;
         $display("FAIL full_drain: got pops=%0d pending=%0d lvl=%0d, required 8 0 0",
                  upd_cnt - base, exp_q.size(), level);
      end
      sb_cycle();
      total++;
      if (underflow !== 1'b0 || dac_upd !== 1'b0) begin
         bad++;
         $display("FAIL full_no_ninth: got uf=%b upd=%b, required 0 0", underflow, dac_upd);
      end
   endtask

   task automatic test_enable_gating();
      int base;
      int start;
      en = 1'b0; rate_div = 16'd5; mode_mid = 1'b0;
      push_sample(10'h2A5); exp_q.push_back(exp_item(0, 10'h2A5));
      push_sample(10'h15A); exp_q.push_back(exp_item(1, 10'h15A));
      base = upd_cnt;
      en = 1'b1;
      repeat (3) sb_cycle();
      en = 1'b0;
      repeat (4) sb_cycle();
      total++;
      if (upd_cnt !== base || level !== 4'd2) begin
         bad++;
         $display("FAIL gate_quiet: got updates=%0d lvl=%0d, required 0 2", upd_cnt - base, level);
      end
      en = 1'b1;
      start = cyc_n;
      repeat (6) sb_cycle();
      total++;
      if (upd_cnt !== base + 1 || last_upd_cyc !== start + 6) begin
         bad++;
         $display("FAIL gate_first_tick: got updates=%0d at=%0d, required 1 at 6",
                  upd_cnt - base, last_upd_cyc - start);
      end
      repeat (6) sb_cycle();
      en = 1'b0;
      total++;
      if (upd_cnt !== base + 2 || last_upd_cyc !== start + 12 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL gate_second_tick: got updates=%0d at=%0d pending=%0d, required 2 at 12 pending 0",
                  upd_cnt - base, last_upd_cyc - start, exp_q.size());
      end
      sb_cycle();
   endtask

   initial begin
      en = 1'b0; rate_div = '0; mode_mid = 1'b0;
      in_data = '0; in_valid = 1'b0; clr_uf = 1'b0;
      test_reset();
      test_round_robin();
      test_underflow_hold();
      test_underflow_mid();
      test_reset_mid();
      test_full_fifo();
      test_enable_gating();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
